// File: rtl/fp_op_pkg.sv
// Shared definitions for the FP op sequencer: state encoding, funct5 opcodes
// and the funct5 -> functional-unit decode.
package fp_op_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_WB     = 3'd4,
    S_DONE   = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  localparam logic [4:0] F5_ADD  = 5'b00000;
  localparam logic [4:0] F5_SUB  = 5'b00001;
  localparam logic [4:0] F5_MUL  = 5'b00010;
  localparam logic [4:0] F5_DIV  = 5'b00011;
  localparam logic [4:0] F5_SQRT = 5'b01011;

  typedef struct packed {
    logic       legal;
    logic [1:0] idx;
    logic       sub;
  } dec_t;

  // Opcode legality only; the NUM_UNITS bound is applied by the sequencer.
  function automatic dec_t decode_f5(input logic [4:0] f5);
    dec_t d;
    d = '0;
    case (f5)
      F5_ADD:  d = '{legal: 1'b1, idx: 2'd0, sub: 1'b0};
      F5_SUB:  d = '{legal: 1'b1, idx: 2'd0, sub: 1'b1};
      F5_MUL:  d = '{legal: 1'b1, idx: 2'd1, sub: 1'b0};
      F5_DIV:  d = '{legal: 1'b1, idx: 2'd2, sub: 1'b0};
      F5_SQRT: d = '{legal: 1'b1, idx: 2'd3, sub: 1'b0};
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/fp_op_timer.sv
// WAIT-state watchdog: counts enabled cycles since the last clear and flags
// the LIMIT-th enabled cycle.
module fp_op_timer #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q counts completed WAIT cycles, so LIMIT-1 marks the LIMIT-th one.
  assign expired = en && (cnt_q == CW'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                cnt_d = '0;
    else if (en && !expired) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fsm_fp_op_multi.sv
// Multi-unit FP operation sequencer: decode, issue to one unit, wait, write back.
// Optional WAIT watchdog enabled by FSM_FP_OP_TIMEOUT_EN.
module fsm_fp_op_multi
  import fp_op_pkg::*;
#(
  parameter int NUM_UNITS      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          insn,
  input  logic                 start,
  input  logic [NUM_UNITS-1:0] done_fp,
  output logic                 load_rs1_fp,
  output logic                 load_rs2_fp,
  output logic [NUM_UNITS-1:0] start_unit,
  output logic                 sub_fp,
  output logic                 load_alu_fp,
  output logic                 load_fp_regfile,
  output logic                 load_pc,
  output logic                 done,
  output logic                 fp_trap,
  output logic                 busy
);

  if (NUM_UNITS < 2 || NUM_UNITS > 4 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1023) begin : g_bad_cfg
    $error("fsm_fp_op_multi: parameter out of range");
  end

  state_e     state_q, state_d;
  logic [1:0] idx_q;
  logic       sub_q;
  dec_t       dec;
  logic       dec_ok;
  logic [3:0] done_ext;
  logic [3:0] start_oh;
  logic       done_sel;
  logic       tmo;
  logic       unused_insn;

  assign unused_insn = ^insn[26:0];
  assign dec    = decode_f5(insn[31:27]);
  assign dec_ok = dec.legal && (int'(dec.idx) < NUM_UNITS);

  // Widen to 4 so a 2-bit index is always in range regardless of NUM_UNITS.
  always_comb begin
    done_ext = '0;
    done_ext[NUM_UNITS-1:0] = done_fp;
  end
  assign done_sel = done_ext[idx_q];

`ifdef FSM_FP_OP_TIMEOUT_EN
  fp_op_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q == S_ISSUE),
    .en      (state_q == S_WAIT),
    .expired (tmo)
  );
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d         = S_IDLE;
    load_rs1_fp     = 1'b0;
    load_rs2_fp     = 1'b0;
    start_oh        = '0;
    sub_fp          = 1'b0;
    load_alu_fp     = 1'b0;
    load_fp_regfile = 1'b0;
    load_pc         = 1'b0;
    done            = 1'b0;
    fp_trap         = 1'b0;
    busy            = 1'b0;
    case (state_q)
      S_IDLE: state_d = start ? S_DECODE : S_IDLE;
      S_DECODE: begin
        busy        = 1'b1;
        load_rs1_fp = 1'b1;
        load_rs2_fp = 1'b1;
        state_d     = dec_ok ? S_ISSUE : S_TRAP;
      end
      S_ISSUE: begin
        busy            = 1'b1;
        start_oh[idx_q] = 1'b1;
        load_alu_fp     = 1'b1;
        sub_fp          = sub_q;
        state_d         = done_sel ? S_WB : S_WAIT;
      end
      S_WAIT: begin
        busy        = 1'b1;
        load_alu_fp = 1'b1;
        sub_fp      = sub_q;
        // A completion in the expiry cycle still wins over the trap.
        if (done_sel) state_d = S_WB;
        else if (tmo) state_d = S_TRAP;
        else          state_d = S_WAIT;
      end
      S_WB: begin
        busy            = 1'b1;
        load_pc         = 1'b1;
        load_fp_regfile = 1'b1;
        state_d         = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_TRAP: begin
        busy    = 1'b1;
        done    = 1'b1;
        fp_trap = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign start_unit = start_oh[NUM_UNITS-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        idx_q <= dec.idx;
        sub_q <= dec.sub;
      end
    end
  end

endmodule

// File: tb/tb_fsm_fp_op_multi.sv
// Directed bench for fsm_fp_op_multi (4-unit DUT plus a 3-unit DUT for the
// unit-bound trap); watchdog checks compile in with FSM_FP_OP_TIMEOUT_EN.
module tb_fsm_fp_op_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] insn = '0;
  logic        start = 1'b0;
  logic [3:0]  done_fp = '0;

  logic       load_rs1_fp, load_rs2_fp, sub_fp, load_alu_fp, load_fp_regfile, load_pc, done, fp_trap, busy;
  logic [3:0] start_unit;

  logic       done3, fp_trap3, load_pc3, busy3;
  logic       unused_rs1_3, unused_rs2_3, unused_sub3, unused_alu3, unused_rf3;
  logic [2:0] unused_su3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fsm_fp_op_multi #(.NUM_UNITS(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .insn(insn), .start(start), .done_fp(done_fp),
    .load_rs1_fp(load_rs1_fp), .load_rs2_fp(load_rs2_fp), .start_unit(start_unit),
    .sub_fp(sub_fp), .load_alu_fp(load_alu_fp), .load_fp_regfile(load_fp_regfile),
    .load_pc(load_pc), .done(done), .fp_trap(fp_trap), .busy(busy)
  );

  fsm_fp_op_multi #(.NUM_UNITS(3), .TIMEOUT_CYCLES(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .insn(insn), .start(start), .done_fp(done_fp[2:0]),
    .load_rs1_fp(unused_rs1_3), .load_rs2_fp(unused_rs2_3), .start_unit(unused_su3),
    .sub_fp(unused_sub3), .load_alu_fp(unused_alu3), .load_fp_regfile(unused_rf3),
    .load_pc(load_pc3), .done(done3), .fp_trap(fp_trap3), .busy(busy3)
  );

  typedef struct {
    logic [4:0] f5;
    int         dly;    // WAIT cycles before done_fp[idx]; 0 = high in ISSUE
    logic [3:0] wrong;  // pattern driven before the real completion
    logic       trap;
    logic [1:0] idx;
    logic       sub;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    logic [3:0] oh;
    oh = 4'b0001 << v.idx;
    @(negedge clk);
    insn  = {v.f5, 27'h5a5a5a5};
    start = 1'b1;
    check("idle_busy", {31'd0, busy}, 0);
    @(negedge clk);
    start = 1'b0;
    check("decode_loads", {30'd0, load_rs1_fp, load_rs2_fp}, 32'h3);
    check("decode_busy", {31'd0, busy}, 1);
    if (v.trap) begin
      @(negedge clk);
      check("trap_done", {30'd0, done, fp_trap}, 32'h3);
      check("trap_wb", {26'd0, load_pc, load_fp_regfile, start_unit}, 0);
      @(negedge clk);
      check("trap_idle", {30'd0, busy, done}, 0);
      return;
    end
    @(negedge clk);
    done_fp = (v.dly == 0) ? oh : v.wrong;
    check("issue_start", {28'd0, start_unit}, {28'd0, oh});
    check("issue_alu_sub", {30'd0, load_alu_fp, sub_fp}, {30'd0, 1'b1, v.sub});
    check("issue_nowb", {30'd0, load_pc, done}, 0);
    if (v.f5 == 5'b01011) check("nu3_trap", {29'd0, done3, fp_trap3, load_pc3}, 32'h6);
    for (int k = 1; k <= v.dly; k++) begin
      @(negedge clk);
      done_fp = (k == v.dly) ? oh : v.wrong;
      check("wait_state", {26'd0, busy, load_alu_fp, sub_fp, start_unit == 4'd0, done, load_pc},
            {26'd0, 1'b1, 1'b1, v.sub, 1'b1, 1'b0, 1'b0});
    end
    @(negedge clk);
    done_fp = '0;
    check("wb_strobes", {29'd0, load_pc, load_fp_regfile, done}, 32'h6);
    check("wb_alu", {31'd0, load_alu_fp}, 0);
    @(negedge clk);
    check("done_pulse", {29'd0, done, fp_trap, busy}, 32'h5);
    check("done_nowb", {30'd0, load_pc, load_fp_regfile}, 0);
    @(negedge clk);
    check("back_idle", {30'd0, busy, done}, 0);
  endtask

  initial begin
    vecs[0] = '{5'b00000, 2, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[1] = '{5'b00001, 0, 4'b0000, 1'b0, 2'd0, 1'b1};
    vecs[2] = '{5'b00010, 5, 4'b0101, 1'b0, 2'd1, 1'b0};
    vecs[3] = '{5'b00011, 1, 4'b1011, 1'b0, 2'd2, 1'b0};
    vecs[4] = '{5'b01011, 0, 4'b0000, 1'b0, 2'd3, 1'b0};
    vecs[5] = '{5'b00100, 0, 4'b0000, 1'b1, 2'd0, 1'b0};
    vecs[6] = '{5'b11111, 0, 4'b0000, 1'b1, 2'd0, 1'b0};
    vecs[7] = '{5'b01010, 0, 4'b0000, 1'b1, 2'd0, 1'b0};

    #2;
    check("reset_outs", {19'd0, load_rs1_fp, load_rs2_fp, start_unit, sub_fp, load_alu_fp,
                         load_fp_regfile, load_pc, done, fp_trap, busy}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("idle_hold", {31'd0, busy}, 0);

    for (int i = 0; i < 8; i++) run_op(vecs[i]);

`ifdef FSM_FP_OP_TIMEOUT_EN
    // done_fp never arrives: trap on the 8th WAIT cycle
    @(negedge clk);
    insn = {5'b00000, 27'd0};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("tmo_issue", {28'd0, start_unit}, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("tmo_wait", {29'd0, busy, load_alu_fp, done}, 32'h6);
    end
    @(negedge clk);
    check("tmo_trap", {28'd0, done, fp_trap, load_pc, load_fp_regfile}, 32'hc);
    @(negedge clk);
    check("tmo_idle", {31'd0, busy}, 0);
    // completion in the expiry cycle wins
    run_op('{5'b00000, 8, 4'b0000, 1'b0, 2'd0, 1'b0});
`else
    run_op('{5'b00011, 20, 4'b0000, 1'b0, 2'd2, 1'b0});
`endif

    // reset mid-WAIT aborts without writeback
    @(negedge clk);
    insn = {5'b00010, 27'd0};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_wait", {30'd0, busy, load_alu_fp}, 32'h3);
    #2 rst_n = 1'b0;
    #1;
    check("rst_outs", {19'd0, load_rs1_fp, load_rs2_fp, start_unit, sub_fp, load_alu_fp,
                       load_fp_regfile, load_pc, done, fp_trap, busy}, 0);
    @(negedge clk);
    check("rst_held", {29'd0, busy, load_pc, load_fp_regfile}, 0);
    rst_n = 1'b1;
    run_op(vecs[2]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fsm_fp_op_multi.md
FSM_FP_OP_MULTI -- requirements
Module: fsm_fp_op_multi

Interface
REQ-001 Parameter NUM_UNITS, default 4: number of FP functional units sequenced (legal 2..4).
REQ-002 Parameter TIMEOUT_CYCLES, default 64: maximum WAIT cycles before trap (legal 2..1023).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 insn  input  32  instruction word; sampled only in DECODE.
REQ-006 start  input  1  leaves IDLE when high.
REQ-007 done_fp  input  NUM_UNITS  per-unit completion flags.
REQ-008 load_rs1_fp, load_rs2_fp  output  1 each  operand register loads.
REQ-009 start_unit  output  NUM_UNITS  one-hot, one-cycle unit start pulse.
REQ-010 sub_fp  output  1  subtract select for unit 0.
REQ-011 load_alu_fp  output  1  result register load.
REQ-012 load_fp_regfile, load_pc  output  1 each  writeback strobes.
REQ-013 done  output  1  operation finished (normal or trap).
REQ-014 fp_trap  output  1  illegal op or timeout, valid with done.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 States: IDLE, DECODE, ISSUE, WAIT, WRITEBACK, DONE, TRAP; outputs are Moore, decoded from state plus latched fields only.
REQ-017 IDLE -> DECODE when start=1; otherwise stay; start ignored in all other states.
REQ-018 DECODE: load_rs1_fp=load_rs2_fp=1; latch unit index and sub bit from insn[31:27]: 00000 -> unit 0 sub=0, 00001 -> unit 0 sub=1, 00010 -> unit 1, 00011 -> unit 2, 01011 -> unit 3.
REQ-019 Any other funct5, or a unit index >= NUM_UNITS, is illegal: DECODE -> TRAP; else DECODE -> ISSUE.
REQ-020 ISSUE: start_unit[idx]=1 for exactly this one cycle, load_alu_fp=1, sub_fp=latched sub; -> WRITEBACK if done_fp[idx]=1, else -> WAIT.
REQ-021 WAIT: load_alu_fp=1, sub_fp held; start_unit all zero; -> WRITEBACK on done_fp[idx]=1; done_fp bits of other units ignored.
REQ-022 WRITEBACK: load_pc=load_fp_regfile=1 for one cycle; -> DONE.
REQ-023 DONE: done=1, fp_trap=0; -> IDLE.
REQ-024 TRAP: done=1, fp_trap=1 for one cycle; load_pc, load_fp_regfile, start_unit all 0; -> IDLE.
REQ-025 Minimum latency start-to-done: 4 cycles (IDLE, DECODE, ISSUE, WRITEBACK, done in DONE) when done_fp[idx] is high in ISSUE.
REQ-026 Unencoded state values -> IDLE next cycle with all outputs deasserted.

Reset
REQ-027 rst_n=0 forces IDLE, clears latched index/sub and the timeout counter immediately; all outputs 0, including mid-operation (in-flight result is never written back).

Configuration
REQ-028 Macro FSM_FP_OP_TIMEOUT_EN defined: counter clears on entering ISSUE, increments each WAIT cycle; WAIT -> TRAP when it reaches TIMEOUT_CYCLES without done_fp[idx]; done_fp[idx] in that same cycle wins (-> WRITEBACK).
REQ-029 Macro undefined: no counter logic; WAIT persists indefinitely until done_fp[idx]; fp_trap asserts only for illegal ops.

Structure
REQ-030 Package fp_op_pkg holds the state encoding (3-bit), funct5 constants and funct5-to-unit-index mapping function.
REQ-031 Timeout counter is sub-module fp_op_timer (clear, enable, limit parameter, expired output), instantiated only under FSM_FP_OP_TIMEOUT_EN.

Verification
REQ-032 insn[31:27]=00000, start 1 cycle, done_fp=0001 two cycles after ISSUE -> start_unit=0001 one cycle, sub_fp=0, one WRITEBACK, done pulse, fp_trap=0.
REQ-033 insn[31:27]=00001 with done_fp[0] high in ISSUE -> sub_fp=1 in ISSUE, done exactly 4 cycles after start sampled.
REQ-034 insn[31:27]=00010, done_fp=0101 (wrong unit) for 5 cycles then 0010 -> stays WAIT until 0010, then WRITEBACK.
REQ-035 insn[31:27]=00100 -> DECODE -> TRAP; done=fp_trap=1, load_pc and load_fp_regfile never asserted; NUM_UNITS=3 with funct5 01011 likewise traps.
REQ-036 FSM_FP_OP_TIMEOUT_EN, TIMEOUT_CYCLES=8, done_fp held 0 -> TRAP after 8 WAIT cycles; rerun with done_fp[idx] on cycle 8 -> WRITEBACK.
REQ-037 rst_n low during WAIT -> outputs 0 same cycle, IDLE, busy=0; next start runs a clean operation.
